// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched
//   Walks the four-bank coefficient memory through every NTT stage after a
//   single start command. Each RUN cycle issues one common bank read address
//   plus the four output-network select codes. The matching bank write
//   strobe/address is the read strobe/address delayed by PIPE_LAT cycles.
//
// Ports
//   clk, rst          clock (rising edge), async active-low reset
//   start             begin a transform; only looked at in IDLE
//   busy              high while reading or draining
//   done              one-cycle completion pulse
//   stage             current stage index
//   rd_en, rd_addr    bank read strobe / common read address
//   sel_a_0..sel_a_3  output-network selects, aligned with the read
//   wr_en, wr_addr    bank write strobe / address (read delayed PIPE_LAT)
module ntt_stage_sched #(
  parameter int ADDR_W   = 6,
  parameter int STAGES   = 7,
  parameter int PIPE_LAT = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [2:0]        stage,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        sel_a_0,
  output logic [1:0]        sel_a_1,
  output logic [1:0]        sel_a_2,
  output logic [1:0]        sel_a_3,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [ADDR_W-1:0] CNT_MAX  = '1;
  localparam logic [DW-1:0]     DRN_LAST = DW'(PIPE_LAT - 1);
  localparam logic [2:0]        STG_LAST = 3'(STAGES - 1);

  // sel index 0..3 maps to sel_a_0..sel_a_3
  localparam logic [3:0][1:0] SEL_EVEN = {2'b10, 2'b11, 2'b00, 2'b01};
  localparam logic [3:0][1:0] SEL_ODD  = {2'b10, 2'b00, 2'b11, 2'b01};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                             state_q, state_d;
  logic [ADDR_W-1:0]                  cnt_q, cnt_d;
  logic [DW-1:0]                      drn_q, drn_d;
  logic [2:0]                         stage_q, stage_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic                               rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]                  rd_addr_q, rd_addr_d;
  logic [3:0][1:0]                    sel_q, sel_d;
  logic [PIPE_LAT-1:0]                vld_pipe_q, vld_pipe_d;
  logic [PIPE_LAT-1:0][ADDR_W-1:0]    addr_pipe_q, addr_pipe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    stage_d = stage_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      S_RUN: begin
        // cnt_q is the address being read this cycle
        if (cnt_q == CNT_MAX) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // hold off reads until the last write of this stage has landed
        if (drn_q == DRN_LAST) begin
          if (stage_q < STG_LAST) begin
            state_d = S_RUN;
            stage_d = stage_q + 3'd1;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // outputs are registered from the next-state view so they line up
    // with the state they describe
    rd_en_d   = (state_d == S_RUN);
    rd_addr_d = cnt_d;
    busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
    sel_d     = sel_q;
    if (rd_en_d) sel_d = stage_d[0] ? SEL_ODD : SEL_EVEN;

    // write-back delay line, keeps shifting in every state
    vld_pipe_d     = vld_pipe_q;
    addr_pipe_d    = addr_pipe_q;
    vld_pipe_d[0]  = rd_en_q;
    addr_pipe_d[0] = rd_addr_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      addr_pipe_d[i] = addr_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      drn_q       <= '0;
      stage_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      sel_q       <= '0;
      vld_pipe_q  <= '0;
      addr_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      stage_q     <= stage_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      sel_q       <= sel_d;
      vld_pipe_q  <= vld_pipe_d;
      addr_pipe_q <= addr_pipe_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign stage   = stage_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign sel_a_0 = sel_q[0];
  assign sel_a_1 = sel_q[1];
  assign sel_a_2 = sel_q[2];
  assign sel_a_3 = sel_q[3];
  assign wr_en   = vld_pipe_q[PIPE_LAT-1];
  assign wr_addr = addr_pipe_q[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Directed bench for ntt_stage_sched: default instance plus a small-parameter
// corner instance (ADDR_W=2, STAGES=1, PIPE_LAT=1) sharing clock and reset.
module tb_ntt_stage_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic start_c = 1'b0;

  logic       busy, done, rd_en, wr_en;
  logic [2:0] stage;
  logic [5:0] rd_addr, wr_addr;
  logic [1:0] sel_a_0, sel_a_1, sel_a_2, sel_a_3;

  logic       c_busy, c_done, c_rd_en, c_wr_en;
  logic [2:0] c_stage;
  logic [1:0] c_rd_addr, c_wr_addr;
  logic [1:0] c_sel_0, c_sel_1, c_sel_2, c_sel_3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_sel = 8'h00;

  // {sel_a_0, sel_a_1, sel_a_2, sel_a_3}
  localparam logic [7:0] SEL_EVEN = 8'b01_00_11_10;
  localparam logic [7:0] SEL_ODD  = 8'b01_11_00_10;

  always #5 clk = ~clk;

  ntt_stage_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .sel_a_0(sel_a_0), .sel_a_1(sel_a_1), .sel_a_2(sel_a_2), .sel_a_3(sel_a_3),
    .wr_en(wr_en), .wr_addr(wr_addr)
  );

  ntt_stage_sched #(.ADDR_W(2), .STAGES(1), .PIPE_LAT(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c),
    .busy(c_busy), .done(c_done), .stage(c_stage),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr),
    .sel_a_0(c_sel_0), .sel_a_1(c_sel_1), .sel_a_2(c_sel_2), .sel_a_3(c_sel_3),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({busy, done, stage, rd_en, rd_addr, sel_a_0, sel_a_1, sel_a_2,
                sel_a_3, wr_en, wr_addr});
  endfunction

  function automatic logic [31:0] all_outs_c();
    return 32'({c_busy, c_done, c_stage, c_rd_en, c_rd_addr, c_sel_0, c_sel_1,
                c_sel_2, c_sel_3, c_wr_en, c_wr_addr});
  endfunction

  // Expected default-instance outputs n cycles after the start edge.
  // Stage period 77 = 64 reads + 13 drain; 7 stages end at n=539, done at 540.
  task automatic step_chk(input int n);
    int  s, p, m;
    bit  rd, wr;
    s  = (n - 1) / 77;
    p  = (n - 1) % 77;
    rd = (n <= 539) && (p < 64);
    chk("busy", 32'(busy), 32'(n <= 539));
    chk("done", 32'(done), 32'(n == 540));
    if (n <= 539) chk("stage", 32'(stage), 32'(s));
    chk("rd_en", 32'(rd_en), 32'(rd));
    if (rd) begin
      chk("rd_addr", 32'(rd_addr), 32'(p));
      exp_sel = (s % 2 == 1) ? SEL_ODD : SEL_EVEN;
    end
    chk("sel", 32'({sel_a_0, sel_a_1, sel_a_2, sel_a_3}), 32'(exp_sel));
    m  = n - 13;
    wr = (m >= 1) && (m <= 539) && (((m - 1) % 77) < 64);
    chk("wr_en", 32'(wr_en), 32'(wr));
    if (wr) chk("wr_addr", 32'(wr_addr), 32'((m - 1) % 77));
  endtask

  initial begin
    // reset values, asserted and then 20 idle cycles
    #12;
    chk("rst_outs", all_outs(), 32'h0);
    chk("rst_outs_c", all_outs_c(), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outs", all_outs(), 32'h0);
      chk("idle_outs_c", all_outs_c(), 32'h0);
    end

    // single start pulse, full transform plus one idle cycle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    step_chk(1);
    for (int n = 2; n <= 545; n++) begin
      @(negedge clk);
      step_chk(n);
    end

    // start held: one transform, then a second one right after done
    start = 1'b1;
    for (int n = 1; n <= 541; n++) begin
      @(negedge clk);
      step_chk(n);
    end
    @(negedge clk);
    start = 1'b0;
    step_chk(1);
    // stage 3, cnt=20 is n = 3*77 + 21
    for (int n = 2; n <= 252; n++) begin
      @(negedge clk);
      step_chk(n);
    end
    chk("mid_stage", 32'(stage), 32'd3);
    chk("mid_addr", 32'(rd_addr), 32'd20);

    // asynchronous abort mid-RUN
    #2 rst = 1'b0;
    #1 chk("abort_outs", all_outs(), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_sel = 8'h00;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("post_abort", all_outs(), 32'h0);
    end

    // full transform after abort
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    step_chk(1);
    for (int n = 2; n <= 541; n++) begin
      @(negedge clk);
      step_chk(n);
    end

    // corner instance: 4 reads, 1 drain, done at +6, writes one cycle late
    start_c = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      start_c = 1'b0;
      chk("c_rd_en", 32'(c_rd_en), 32'(n >= 1 && n <= 4));
      if (n >= 1 && n <= 4) chk("c_rd_addr", 32'(c_rd_addr), 32'(n - 1));
      chk("c_wr_en", 32'(c_wr_en), 32'(n >= 2 && n <= 5));
      if (n >= 2 && n <= 5) chk("c_wr_addr", 32'(c_wr_addr), 32'(n - 2));
      chk("c_busy", 32'(c_busy), 32'(n <= 5));
      chk("c_done", 32'(c_done), 32'(n == 6));
      chk("c_sel", 32'({c_sel_0, c_sel_1, c_sel_2, c_sel_3}), 32'(SEL_EVEN));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
